// File: rtl/blackjack_pkg.sv
// Shared deck constants, FSM state encoding and card record for the dealer.
package blackjack_pkg;

    localparam int unsigned DECK_SIZE      = 52;
    localparam int unsigned RANKS_PER_SUIT = 13;
    localparam int unsigned IDX_W          = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DEAL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
        logic [3:0] points;
    } card_t;

    // Reduce a 6-bit random value into 0..51 with one conditional subtract.
    function automatic logic [IDX_W-1:0] fold(input logic [IDX_W-1:0] v);
        if (v >= IDX_W'(DECK_SIZE)) begin
            fold = v - IDX_W'(DECK_SIZE);
        end else begin
            fold = v;
        end
    endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card index (0..51) to rank/suit/points decoder.
module card_decode
    import blackjack_pkg::*;
#(
    parameter int unsigned ACE_HIGH = 1
) (
    input  logic [IDX_W-1:0] idx,
    output card_t            card
);

    logic [3:0] offset;

    // Suit by threshold compare against multiples of 13, rank from remainder.
    always_comb begin
        card = '0;
        if (idx < IDX_W'(RANKS_PER_SUIT)) begin
            card.suit = 2'd0;
            offset    = 4'(idx);
        end else if (idx < IDX_W'(2 * RANKS_PER_SUIT)) begin
            card.suit = 2'd1;
            offset    = 4'(idx - IDX_W'(RANKS_PER_SUIT));
        end else if (idx < IDX_W'(3 * RANKS_PER_SUIT)) begin
            card.suit = 2'd2;
            offset    = 4'(idx - IDX_W'(2 * RANKS_PER_SUIT));
        end else begin
            card.suit = 2'd3;
            offset    = 4'(idx - IDX_W'(3 * RANKS_PER_SUIT));
        end
        card.rank = offset + 4'd1;
        if (card.rank == 4'd1) begin
            card.points = (ACE_HIGH != 0) ? 4'd11 : 4'd1;
        end else if (card.rank > 4'd10) begin
            card.points = 4'd10;
        end else begin
            card.points = card.rank;
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals random cards without replacement from a 52-card deck tracked by a used bitmap.
module card_dealer
    import blackjack_pkg::*;
#(
    parameter int unsigned ACE_HIGH = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_rand,
    input  logic       i_request,
    input  logic       i_shuffle,
    output logic       o_ready,
    output logic       o_valid,
    output logic [3:0] o_rank,
    output logic [1:0] o_suit,
    output logic [3:0] o_points,
    output logic [5:0] o_cards_left,
    output logic       o_empty
);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DECK_SIZE-1:0]   used_q, used_d;
    card_t                  card_q, card_d;
    logic [5:0]             left_q, left_d;
    card_t                  dec_card;

    card_decode #(
        .ACE_HIGH (ACE_HIGH)
    ) u_card_decode (
        .idx  (idx_q),
        .card (dec_card)
    );

    // State and datapath registers; reset restores a full deck and blank card.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            used_q  <= '0;
            card_q  <= '0;
            left_q  <= 6'(DECK_SIZE);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            used_q  <= used_d;
            card_q  <= card_d;
            left_q  <= left_d;
        end
    end

    // Next-state: accept in IDLE, linear probe for a free slot, one-cycle deal pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        used_d  = used_q;
        card_d  = card_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (i_shuffle) begin
                    used_d = '0;
                    left_d = 6'(DECK_SIZE);
                end else if (i_request && o_ready) begin
                    idx_d   = fold(i_rand);
                    state_d = PROBE;
                end
            end
            PROBE: begin
                if (used_q[idx_q]) begin
                    if (idx_q == IDX_W'(DECK_SIZE - 1)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    used_d[idx_q] = 1'b1;
                    card_d        = dec_card;
                    left_d        = left_q - 6'd1;
                    state_d       = DEAL;
                end
            end
            DEAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        o_empty      = (left_q == 6'd0);
        o_ready      = (state_q == IDLE) && !o_empty && !i_shuffle;
        o_valid      = (state_q == DEAL);
        o_rank       = card_q.rank;
        o_suit       = card_q.suit;
        o_points     = card_q.points;
        o_cards_left = left_q;
    end

endmodule
